multicycle_controller: RTL

Moore/Mealy control FSM that sequences the multicycle 19-bit-instruction CPU datapath. It drives the load enables of the 19-bit IR, the 13-bit PC, the 8-bit accumulator and the 1-bit zero/carry flag registers, plus mux selects, ALU function and memory strobes. Memory is single-ported and shared by instruction fetch and data access, with a `mem_ready` wait-state handshake. The block holds no datapath state; it sees only decoded IR fields and flag values.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/multicycle_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle 19-bit-instruction CPU.
// Used by the controller and the datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_ALU,
    S_MEM_LD,
    S_MEM_ST,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_ALUR  = 3'b000;
  localparam logic [2:0] OP_ALUI  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_JUMP  = 3'b100;
  localparam logic [2:0] OP_BZ    = 3'b101;
  localparam logic [2:0] OP_BC    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic PC_SRC_INC  = 1'b0;
  localparam logic PC_SRC_IR   = 1'b1;
  localparam logic ACC_SRC_ALU = 1'b0;
  localparam logic ACC_SRC_MEM = 1'b1;

  localparam int IR_W       = 19;
  localparam int IR_OP_HI   = 18;
  localparam int IR_OP_LO   = 16;
  localparam int IR_FN_HI   = 15;
  localparam int IR_FN_LO   = 13;
  localparam int IR_ADDR_HI = 12;
  localparam int IR_ADDR_LO = 0;
  localparam int IR_IMM_HI  = 7;
  localparam int IR_IMM_LO  = 0;

endpackage

// File: rtl/multicycle_controller.sv
// Control FSM sequencing fetch/decode/execute over a shared,
// wait-stated memory port. Holds no datapath state.
module multicycle_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] fn,
  input  logic       zero,
  input  logic       carry,
  input  logic       mem_ready,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       acc_ld,
  output logic       flags_ld,
  output logic       pc_src,
  output logic       acc_src,
  output logic       alu_src_b,
  output logic [2:0] alu_fn,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       busy,
  output logic       halted
);

  state_t state_q;
  state_t state_d;
  logic   take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      op == OP_JUMP: take = 1'b1;
      op == OP_BZ:   take = zero;
      op == OP_BC:   take = carry;
      default:       take = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_ld     = 1'b0;
    ir_ld     = 1'b0;
    acc_ld    = 1'b0;
    flags_ld  = 1'b0;
    pc_src    = PC_SRC_INC;
    acc_src   = ACC_SRC_ALU;
    alu_src_b = 1'b0;
    alu_fn    = 3'b000;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b1;
    halted    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_ld   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_ALUR, OP_ALUI:       state_d = S_EXEC_ALU;
          OP_LOAD:                state_d = S_MEM_LD;
          OP_STORE:               state_d = S_MEM_ST;
          OP_JUMP, OP_BZ, OP_BC:  state_d = S_BRANCH;
          OP_HALT:                state_d = S_HALT;
        endcase
      end
      S_EXEC_ALU: begin
        alu_fn    = fn;
        alu_src_b = op[0];
        // register form reads its B operand from memory first
        if (op[0]) begin
          acc_ld   = 1'b1;
          flags_ld = 1'b1;
          state_d  = S_FETCH;
        end else begin
          iord   = 1'b1;
          mem_rd = 1'b1;
          if (mem_ready) begin
            acc_ld   = 1'b1;
            flags_ld = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_MEM_LD: begin
        iord    = 1'b1;
        mem_rd  = 1'b1;
        acc_src = ACC_SRC_MEM;
        if (mem_ready) begin
          acc_ld  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_ST: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        pc_src  = PC_SRC_IR;
        pc_ld   = take;
        state_d = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
    endcase
  end

endmodule
